ifmap_multi_fifo_ctrl: RTL and testbench

IFMAP_MULTI_FIFO_CTRL -- requirements
Module: ifmap_multi_fifo_ctrl

---
 rtl/ifmap_multi_fifo_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ifmap_multi_fifo_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_multi_fifo_ctrl.sv
// Multi-channel ifmap FIFO controller: each channel drains its FIFO, refills it
// from the GLB through one shared round-robin read port, and reports completion.

module ifmap_ch_fsm #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              start_i,
  input  logic              run_i,
  input  logic [CNT_W-1:0]  pop_num_i,
  input  logic              burst_i,
  input  logic              fifo_full_i,
  input  logic              fifo_empty_i,
  input  logic              push_i,
  input  logic              done_i,
  output logic              req_o,
  output logic              pop_en_o,
  output logic              fin_o,
  output logic [ADDR_W-1:0] read_ptr_o
);
  typedef enum logic [1:0] {S_IDLE, S_POP, S_PUSH, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d   = state_q;
    pop_cnt_d = pop_cnt_q;
    ptr_d     = ptr_q;
    req_o     = 1'b0;
    pop_en_o  = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        pop_cnt_d = '0;
        state_d   = run_i ? S_POP : S_FIN;
      end
      S_POP: begin
        pop_en_o = !fifo_empty_i;
        if (!fifo_empty_i) begin
          pop_cnt_d = pop_cnt_q + CNT_W'(1);
          if (pop_cnt_q == pop_num_i - CNT_W'(1)) state_d = S_FIN;
        end else begin
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        // Push strobe can only arrive while requesting, i.e. while not full.
        req_o = !fifo_full_i;
        if (push_i) ptr_d = ptr_q + (burst_i ? ADDR_W'(4) : ADDR_W'(1));
        if (fifo_full_i) state_d = S_POP;
      end
      S_FIN: if (done_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      state_q   <= S_IDLE;
      pop_cnt_q <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pop_cnt_q <= pop_cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign fin_o      = (state_q == S_FIN);
  assign read_ptr_o = ptr_q;
endmodule

module ifmap_multi_fifo_ctrl #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_reset_i,
  input  logic                     start_i,
  input  logic [CNT_W-1:0]         pop_num_i,
  input  logic                     burst_mode_i,
  input  logic [NUM_CH-1:0]        ch_en_i,
  input  logic [NUM_CH*ADDR_W-1:0] base_addr_i,
  input  logic [NUM_CH-1:0]        fifo_full_i,
  input  logic [NUM_CH-1:0]        fifo_empty_i,
  input  logic                     glb_gnt_i,
  input  logic [DATA_W-1:0]        glb_rdata_i,
  output logic                     fifo_reset_o,
  output logic [NUM_CH-1:0]        fifo_push_en_o,
  output logic [NUM_CH-1:0]        fifo_pop_en_o,
  output logic [DATA_W-1:0]        fifo_push_data_o,
  output logic                     fifo_push_mod_o,
  output logic                     glb_read_req_o,
  output logic [ADDR_W-1:0]        glb_read_addr_o,
  output logic                     busy_o,
  output logic                     done_o
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                          busy_q, burst_q;
  logic [CNT_W-1:0]              pop_num_q;
  logic [IDX_W-1:0]              rr_q, sel, idx;
  logic                          accept, req_any, push_any;
  logic [NUM_CH-1:0]             req, fin, push;
  logic [NUM_CH-1:0][ADDR_W-1:0] base, ptr;

  assign accept = start_i && !busy_q && !fifo_reset_i;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign base[c] = base_addr_i[c*ADDR_W +: ADDR_W];
    assign push[c] = push_any && (sel == IDX_W'(c));

    ifmap_ch_fsm #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_ch (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (fifo_reset_i),
      .start_i      (accept),
      .run_i        (ch_en_i[c] && (pop_num_i != '0)),
      .pop_num_i    (pop_num_q),
      .burst_i      (burst_q),
      .fifo_full_i  (fifo_full_i[c]),
      .fifo_empty_i (fifo_empty_i[c]),
      .push_i       (push[c]),
      .done_i       (done_o),
      .req_o        (req[c]),
      .pop_en_o     (fifo_pop_en_o[c]),
      .fin_o        (fin[c]),
      .read_ptr_o   (ptr[c])
    );
  end

  // Round-robin scan begins one past the last granted channel.
  always_comb begin
    sel     = '0;
    req_any = 1'b0;
    idx     = rr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (idx == IDX_W'(NUM_CH - 1)) ? '0 : idx + IDX_W'(1);
      if (!req_any && req[idx]) begin
        sel     = idx;
        req_any = 1'b1;
      end
    end
  end

  assign push_any         = glb_gnt_i && req_any;
  assign fifo_push_en_o   = push;
  assign fifo_push_data_o = push_any ? glb_rdata_i : '0;
  assign fifo_push_mod_o  = burst_q;
  assign glb_read_req_o   = req_any;
  assign glb_read_addr_o  = base[sel] + ptr[sel];
  assign fifo_reset_o     = fifo_reset_i;
  assign busy_o           = busy_q;
  assign done_o           = busy_q && (&fin) && !fifo_reset_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      burst_q   <= 1'b0;
      pop_num_q <= '0;
      rr_q      <= '0;
    end else if (fifo_reset_i) begin
      busy_q <= 1'b0;
      rr_q   <= '0;
    end else begin
      if (accept) begin
        busy_q    <= 1'b1;
        burst_q   <= burst_mode_i;
        pop_num_q <= pop_num_i;
      end else if (done_o) begin
        busy_q <= 1'b0;
      end
      if (push_any) rr_q <= sel;
    end
  end
endmodule

// File: tb/tb_ifmap_multi_fifo_ctrl.sv
// Bench for ifmap_multi_fifo_ctrl: FIFO occupancy model, expected-address and
// per-task scoreboards, directed scenarios followed by random tasks.

module tb_ifmap_multi_fifo_ctrl;
  localparam int NUM_CH = 4, DATA_W = 32, ADDR_W = 32, CNT_W = 16;

  logic clk = 1'b0, rst;
  logic fifo_reset_i, start_i, burst_mode_i, glb_gnt_i;
  logic [CNT_W-1:0] pop_num_i;
  logic [NUM_CH-1:0] ch_en_i, fifo_full_i, fifo_empty_i;
  logic [NUM_CH*ADDR_W-1:0] base_addr_i;
  logic [DATA_W-1:0] glb_rdata_i, fifo_push_data_o;
  logic fifo_reset_o, fifo_push_mod_o, glb_read_req_o, busy_o, done_o;
  logic [NUM_CH-1:0] fifo_push_en_o, fifo_pop_en_o;
  logic [ADDR_W-1:0] glb_read_addr_o;

  ifmap_multi_fifo_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fifo_reset_i(fifo_reset_i), .start_i(start_i),
    .pop_num_i(pop_num_i), .burst_mode_i(burst_mode_i), .ch_en_i(ch_en_i),
    .base_addr_i(base_addr_i), .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
    .glb_gnt_i(glb_gnt_i), .glb_rdata_i(glb_rdata_i), .fifo_reset_o(fifo_reset_o),
    .fifo_push_en_o(fifo_push_en_o), .fifo_pop_en_o(fifo_pop_en_o),
    .fifo_push_data_o(fifo_push_data_o), .fifo_push_mod_o(fifo_push_mod_o),
    .glb_read_req_o(glb_read_req_o), .glb_read_addr_o(glb_read_addr_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0][15:0] pops;
    int lat;
    int scyc;
  } task_t;

  task_t tq[$];
  task_t mon_t;
  logic [ADDR_W-1:0] qexp[NUM_CH][$];
  logic [ADDR_W-1:0] ptr_model[NUM_CH];
  int occ[NUM_CH], depth[NUM_CH], pops_mon[NUM_CH];
  int push_log[$];
  int n_tests = 0, n_fail = 0, cyc = 0, gnt_mode = 1;
  bit mon_en = 0, prev_done = 0, exp_burst = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO environment: status follows the bench occupancy model.
  always @(posedge clk) begin
    cyc++;
    #2;
    for (int c = 0; c < NUM_CH; c++) begin
      fifo_empty_i[c] = (occ[c] == 0);
      fifo_full_i[c]  = (occ[c] >= depth[c]);
    end
    glb_gnt_i   = (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : (gnt_mode == 1);
    glb_rdata_i = $urandom;
  end

  // Monitor: pops expectations whenever the DUT strobes or completes.
  always @(negedge clk) if (mon_en) begin
    check("reset_passthru", 64'(fifo_reset_o), 64'(fifo_reset_i));
    if (|fifo_push_en_o) begin
      check("push_onehot", 64'($onehot(fifo_push_en_o)), 64'(1));
      check("push_gnt", 64'(glb_gnt_i), 64'(1));
      check("push_req", 64'(glb_read_req_o), 64'(1));
      check("push_data", 64'(fifo_push_data_o), 64'(glb_rdata_i));
      check("push_mod", 64'(fifo_push_mod_o), 64'(exp_burst));
    end
    for (int c = 0; c < NUM_CH; c++) begin
      check("push_pop_excl", 64'(fifo_push_en_o[c] & fifo_pop_en_o[c]), 64'(0));
      if (fifo_pop_en_o[c]) begin
        check("pop_nonempty", 64'(occ[c] > 0), 64'(1));
        if (occ[c] > 0) occ[c]--;
        pops_mon[c]++;
      end
      if (fifo_push_en_o[c]) begin
        check("push_notfull", 64'(occ[c] < depth[c]), 64'(1));
        check("push_expected", 64'(qexp[c].size() > 0), 64'(1));
        if (qexp[c].size() > 0) check("push_addr", 64'(glb_read_addr_o), 64'(qexp[c].pop_front()));
        occ[c]++;
        ptr_model[c] += exp_burst ? 4 : 1;
        push_log.push_back(c);
      end
    end
    if (prev_done) begin
      check("done_one_cycle", 64'(done_o), 64'(0));
      check("busy_drop", 64'(busy_o), 64'(0));
    end
    if (done_o) begin
      check("done_expected", 64'(tq.size() > 0), 64'(1));
      if (tq.size() > 0) begin
        mon_t = tq.pop_front();
        for (int c = 0; c < NUM_CH; c++)
          check("pop_count", 64'(pops_mon[c]), 64'(mon_t.pops[c]));
        if (mon_t.lat >= 0) check("done_latency", 64'(cyc - mon_t.scyc), 64'(mon_t.lat));
      end
    end
    prev_done = done_o;
  end

  // Called at posedge+1 with the DUT idle.
  task automatic start_task(input logic [NUM_CH-1:0] en, input int pn, input bit burst);
    task_t t;
    logic [ADDR_W-1:0] a;
    for (int c = 0; c < NUM_CH; c++) begin
      pops_mon[c] = 0;
      qexp[c].delete();
      if (en[c] && pn > 0)
        for (int k = 0; k < 40; k++) begin
          a = base_addr_i[c*ADDR_W +: ADDR_W] + ptr_model[c] + ADDR_W'(k * (burst ? 4 : 1));
          qexp[c].push_back(a);
        end
      t.pops[c] = (en[c] && pn > 0) ? 16'(pn) : 16'(0);
    end
    t.lat  = (pn == 0 || en == '0) ? 1 : -1;
    t.scyc = cyc;
    exp_burst = burst;
    tq.push_back(t);
    ch_en_i = en; pop_num_i = CNT_W'(pn); burst_mode_i = burst; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; ch_en_i = NUM_CH'($urandom); pop_num_i = CNT_W'($urandom); burst_mode_i = 1'($urandom);
    #2 check("busy_after_start", 64'(busy_o), 64'(1));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(posedge clk); #1;
    while (busy_o && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("task_timeout", 64'(busy_o), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_fifo_reset();
    int saved = gnt_mode;
    gnt_mode = 0;
    fifo_reset_i = 1'b1;
    @(posedge clk); #1;
    fifo_reset_i = 1'b0;
    tq.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      qexp[c].delete();
      ptr_model[c] = '0;
    end
    gnt_mode = saved;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fifo_reset_i = 1'b0; start_i = 1'b0; pop_num_i = '0; burst_mode_i = 1'b0;
    ch_en_i = '0; glb_gnt_i = 1'b0; glb_rdata_i = '0; fifo_full_i = '0; fifo_empty_i = '1;
    base_addr_i = {32'h3000_0000, 32'h2000_0000, 32'h1000_0400, 32'h0000_1000};
    for (int c = 0; c < NUM_CH; c++) begin
      occ[c] = 0; depth[c] = 4; ptr_model[c] = '0; pops_mon[c] = 0;
    end
    gnt_mode = 1;
    repeat (3) @(posedge clk);
    #3;
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_push_en", 64'(fifo_push_en_o), 64'(0));
    check("rst_pop_en", 64'(fifo_pop_en_o), 64'(0));
    check("rst_push_data", 64'(fifo_push_data_o), 64'(0));
    check("rst_push_mod", 64'(fifo_push_mod_o), 64'(0));
    check("rst_req", 64'(glb_read_req_o), 64'(0));
    check("rst_addr", 64'(glb_read_addr_o), 64'(32'h0000_1000));
    check("rst_fifo_reset", 64'(fifo_reset_o), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; mon_en = 1'b1;
    @(posedge clk); #1;

    // Channels 0 and 2 drain 3 entries; a start mid-task must be ignored.
    for (int c = 0; c < NUM_CH; c++) begin occ[c] = 10; depth[c] = 16; end
    start_task(4'b0101, 3, 1'b0);
    @(posedge clk); #1;
    start_i = 1'b1; pop_num_i = 7; ch_en_i = 4'hF;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_idle(200);

    // Empty channel refills twice with byte pushes, then pops twice.
    occ[0] = 0; depth[0] = 2; push_log.delete();
    start_task(4'b0001, 2, 1'b0);
    wait_idle(200);
    check("scn2_push_count", 64'(push_log.size()), 64'(2));

    // Two refilling channels share grants alternately.
    do_fifo_reset();
    occ[0] = 0; occ[1] = 0; depth[0] = 4; depth[1] = 4; push_log.delete();
    start_task(4'b0011, 1, 1'b0);
    wait_idle(200);
    check("rr_push_count", 64'(push_log.size()), 64'(8));
    for (int i = 0; i < push_log.size() && i < 8; i++)
      check("rr_order", 64'(push_log[i]), 64'((i % 2 == 0) ? 1 : 0));

    // Word pushes wrap the address space.
    do_fifo_reset();
    base_addr_i[31:0] = 32'hFFFF_FFFC;
    occ[0] = 0; depth[0] = 3; push_log.delete();
    start_task(4'b0001, 1, 1'b1);
    wait_idle(200);
    check("burst_push_count", 64'(push_log.size()), 64'(3));
    base_addr_i[31:0] = 32'h0000_1000;

    // Zero pops completes immediately.
    start_task(4'b1111, 0, 1'b0);
    wait_idle(50);

    // Abort in the middle of a refill.
    occ[0] = 0; depth[0] = 8; push_log.delete(); gnt_mode = 1;
    start_task(4'b0001, 5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    do_fifo_reset();
    #2;
    check("abort_had_pushes", 64'(push_log.size() > 0), 64'(1));
    check("abort_busy", 64'(busy_o), 64'(0));
    check("abort_req", 64'(glb_read_req_o), 64'(0));
    check("abort_ptr_cleared", 64'(glb_read_addr_o), 64'(32'h0000_1000));
    repeat (5) @(posedge clk);
    #1;
    occ[0] = 0; depth[0] = 2;
    start_task(4'b0001, 1, 1'b0);
    wait_idle(200);

    // Random tasks with random grants.
    gnt_mode = 2;
    for (int t = 0; t < 30; t++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        depth[c] = $urandom_range(1, 4);
        occ[c]   = $urandom_range(0, depth[c]);
      end
      if (t % 7 == 3) base_addr_i = {$urandom, $urandom, $urandom, $urandom};
      start_task(NUM_CH'($urandom), $urandom_range(0, 6), 1'($urandom));
      wait_idle(3000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
